// File: rtl/terrain_pkg.sv
// Shared types and screen geometry for the destructible terrain heightmap.
package terrain_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef logic [9:0] height_t;
   typedef logic [9:0] col_t;

   typedef enum logic [1:0] {
      StInit,
      StIdle,
      StCarveRd,
      StCarveWr
   } terrain_state_e;

endpackage

// File: rtl/terrain_height_ram.sv
// Per-column height storage: port A is a display-only read port, port B is the
// FSM read/write port. Both ports are read-first, so a same-cycle write is seen next read.
module terrain_height_ram
   import terrain_pkg::*;
#(
   parameter int unsigned Depth = SCREEN_W
) (
   input  logic    clk,
   input  col_t    i_a_addr,
   output height_t o_a_rdata,
   input  col_t    i_b_addr,
   input  logic    i_b_we,
   input  height_t i_b_wdata,
   output height_t o_b_rdata
);

   height_t r_mem [Depth];
   height_t r_a_rdata;
   height_t r_b_rdata;

   always_ff @(posedge clk) begin
      if (32'(i_a_addr) < Depth) begin
         r_a_rdata <= r_mem[i_a_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (32'(i_b_addr) < Depth) begin
         r_b_rdata <= r_mem[i_b_addr];
         if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
         end
      end
   end

   assign o_a_rdata = r_a_rdata;
   assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/terrain_height_map.sv
// Destructible terrain: heightmap init, crater carving over req/ack, and the
// per-column occupancy mask streamed to the colour mapper two cycles after DrawX.
module terrain_height_map #(
   parameter logic [9:0]  INIT_HEIGHT = 10'd360,
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic [9:0]          DrawX,
   output logic [SCREEN_H-1:0] terrain_data,
   input  logic                carve_req,
   input  logic [9:0]          carve_cx,
   input  logic [9:0]          carve_cy,
   input  logic [5:0]          carve_r,
   output logic                carve_ack,
   output logic                busy
);

   import terrain_pkg::height_t;
   import terrain_pkg::col_t;
   import terrain_pkg::terrain_state_e;
   import terrain_pkg::StInit;
   import terrain_pkg::StIdle;
   import terrain_pkg::StCarveRd;
   import terrain_pkg::StCarveWr;

   localparam col_t        LastCol   = col_t'(SCREEN_W - 1);
   localparam logic [11:0] HeightMax = 12'(SCREEN_H);

   terrain_state_e r_state, w_state_next;
   col_t           r_x, w_x_next;
   col_t           r_x_hi, w_x_hi_next;
   col_t           r_cx;
   height_t        r_cy;
   logic [5:0]     r_r;
   logic           r_ack, w_ack_next;
   logic           w_latch;

   col_t           w_b_addr;
   logic           w_b_we;
   height_t        w_b_wdata;
   height_t        w_b_rdata;
   height_t        w_a_rdata;

   logic                r_blank;
   logic [SCREEN_H-1:0] r_terrain_data;
   logic [SCREEN_H-1:0] w_mask;

   // Column range of a new request, taken straight from the request operands.
   logic signed [10:0] w_lo_s;
   logic [10:0]        w_hi_u;
   col_t               w_x_lo;
   col_t               w_x_hi;

   assign w_lo_s = $signed({1'b0, carve_cx}) - $signed({5'b0, carve_r});
   assign w_hi_u = {1'b0, carve_cx} + {5'b0, carve_r};
   assign w_x_lo = w_lo_s[10] ? '0 : col_t'(w_lo_s[9:0]);
   assign w_x_hi = (w_hi_u > {1'b0, LastCol}) ? LastCol : w_hi_u[9:0];

   // |x - cx| never exceeds r inside the range, so the raw bottom cannot underflow.
   col_t        w_dist;
   logic [11:0] w_bottom_raw;
   height_t     w_bottom;
   height_t     w_new;

   assign w_dist       = (r_x >= r_cx) ? (r_x - r_cx) : (r_cx - r_x);
   assign w_bottom_raw = {2'b0, r_cy} + {6'b0, r_r} - {2'b0, w_dist};
   assign w_bottom     = (w_bottom_raw > HeightMax) ? HeightMax[9:0] : w_bottom_raw[9:0];
   assign w_new        = (w_bottom > w_b_rdata) ? w_bottom : w_b_rdata;

   always_comb begin
      w_state_next = r_state;
      w_x_next     = r_x;
      w_x_hi_next  = r_x_hi;
      w_ack_next   = 1'b0;
      w_latch      = 1'b0;
      w_b_addr     = r_x;
      w_b_we       = 1'b0;
      w_b_wdata    = w_new;
      unique case (r_state)
         StInit: begin
            w_b_we    = 1'b1;
            w_b_wdata = INIT_HEIGHT;
            if (r_x == LastCol) begin
               w_state_next = StIdle;
            end else begin
               w_x_next = r_x + col_t'(1);
            end
         end
         StIdle: begin
            // A request still high during its own ack cycle is the old one.
            if (carve_req && !r_ack) begin
               w_latch = 1'b1;
               if (carve_cx > LastCol) begin
                  w_ack_next = 1'b1;
               end else begin
                  w_x_next     = w_x_lo;
                  w_x_hi_next  = w_x_hi;
                  w_state_next = StCarveRd;
               end
            end
         end
         StCarveRd: begin
            w_state_next = StCarveWr;
            w_ack_next   = (r_x == r_x_hi);
         end
         StCarveWr: begin
            w_b_we = (w_new != w_b_rdata);
            if (r_x == r_x_hi) begin
               w_state_next = StIdle;
            end else begin
               w_x_next     = r_x + col_t'(1);
               w_state_next = StCarveRd;
            end
         end
         default: w_state_next = StInit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= StInit;
         r_x     <= '0;
         r_x_hi  <= '0;
         r_cx    <= '0;
         r_cy    <= '0;
         r_r     <= '0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_x     <= w_x_next;
         r_x_hi  <= w_x_hi_next;
         r_ack   <= w_ack_next;
         if (w_latch) begin
            r_cx <= carve_cx;
            r_cy <= carve_cy;
            r_r  <= carve_r;
         end
      end
   end

   terrain_height_ram #(
      .Depth (SCREEN_W)
   ) u_ram (
      .clk       (clk),
      .i_a_addr  (DrawX),
      .o_a_rdata (w_a_rdata),
      .i_b_addr  (w_b_addr),
      .i_b_we    (w_b_we),
      .i_b_wdata (w_b_wdata),
      .o_b_rdata (w_b_rdata)
   );

   always_comb begin
      w_mask = '0;
      for (int y = 0; y < SCREEN_H; y++) begin
         w_mask[y] = (y >= int'(w_a_rdata));
      end
   end

   // Blank flag travels alongside the RAM read so it lines up with its height.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_blank        <= 1'b1;
         r_terrain_data <= '0;
      end else begin
         r_blank        <= (DrawX > LastCol);
         r_terrain_data <= r_blank ? '0 : w_mask;
      end
   end

   assign terrain_data = r_terrain_data;
   assign carve_ack    = r_ack;
   assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_terrain_height_map.sv
// Randomised carve stimulus checked through the display port against a plain
// array model of the heightmap.
module tb_terrain_height_map;

   logic         clk = 1'b0;
   logic         Reset;
   logic [9:0]   DrawX;
   logic [479:0] terrain_data;
   logic         carve_req;
   logic [9:0]   carve_cx;
   logic [9:0]   carve_cy;
   logic [5:0]   carve_r;
   logic         carve_ack;
   logic         busy;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   int          model_h[640];

   always #5 clk = ~clk;

   terrain_height_map dut (
      .clk          (clk),
      .Reset        (Reset),
      .DrawX        (DrawX),
      .terrain_data (terrain_data),
      .carve_req    (carve_req),
      .carve_cx     (carve_cx),
      .carve_cy     (carve_cy),
      .carve_r      (carve_r),
      .carve_ack    (carve_ack),
      .busy         (busy)
   );

   task automatic check_eq(input string tag, input logic [479:0] obs, input logic [479:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [479:0] mask_of(input int h);
      logic [479:0] m;
      for (int y = 0; y < 480; y++) m[y] = (y >= h);
      return m;
   endfunction

   // Applies a carve to the model and returns the expected request-to-ack latency.
   function automatic int model_carve(input int cx, input int cy, input int r);
      int lo, hi, b;
      if (cx >= 640) return 1;
      lo = (cx - r < 0) ? 0 : cx - r;
      hi = (cx + r > 639) ? 639 : cx + r;
      for (int x = lo; x <= hi; x++) begin
         b = cy + r - ((x > cx) ? x - cx : cx - x);
         if (b > 480) b = 480;
         if (b > model_h[x]) model_h[x] = b;
      end
      return 2 * (hi - lo + 1);
   endfunction

   task automatic check_col(input int c, input string tag);
      DrawX = 10'(c);
      repeat (2) @(posedge clk);
      #1;
      check_eq(tag, terrain_data, (c < 640) ? mask_of(model_h[c]) : 480'd0);
   endtask

   task automatic check_col_const(input int c, input int h, input string tag);
      DrawX = 10'(c);
      repeat (2) @(posedge clk);
      #1;
      check_eq(tag, terrain_data, mask_of(h));
   endtask

   task automatic apply_reset();
      int cnt;
      int acks;
      Reset = 1'b1;
      @(posedge clk);
      #1;
      Reset = 1'b0;
      check_eq("rst_terrain_data", terrain_data, 480'd0);
      check_eq("rst_ack", 480'(carve_ack), 480'd0);
      check_eq("rst_busy", 480'(busy), 480'd1);
      cnt  = 0;
      acks = 0;
      while (busy && cnt < 2000) begin
         cnt++;
         @(posedge clk);
         #1;
         if (carve_ack) acks++;
      end
      check_eq("init_busy_cycles", 480'(cnt), 480'd640);
      check_eq("init_no_ack", 480'(acks), 480'd0);
      for (int i = 0; i < 640; i++) model_h[i] = 360;
   endtask

   task automatic do_carve(input int cx, input int cy, input int r, input string tag);
      int lat;
      int exp_lat;
      bit got;
      carve_cx  = 10'(cx);
      carve_cy  = 10'(cy);
      carve_r   = 6'(r);
      carve_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 3000) begin
         @(posedge clk);
         #1;
         lat++;
         if (carve_ack) got = 1'b1;
      end
      carve_req = 1'b0;
      exp_lat = model_carve(cx, cy, r);
      check_eq({tag, "_ack_latency"}, 480'(lat), 480'(exp_lat));
      @(posedge clk);
      #1;
      check_eq({tag, "_ack_pulse"}, 480'(carve_ack), 480'd0);
      check_eq({tag, "_idle"}, 480'(busy), 480'd0);
   endtask

   initial begin
      int cx, cy, r;
      DrawX     = 10'd100;
      carve_req = 1'b1;
      carve_cx  = 10'd320;
      carve_cy  = 10'd360;
      carve_r   = 6'd10;

      // Request held through INIT must be serviced only afterwards.
      apply_reset();
      do_carve(320, 360, 10, "centre");
      check_col_const(100, 360, "init_col100");
      check_col_const(320, 370, "centre_320");
      check_col_const(315, 365, "centre_315");
      check_col_const(310, 360, "centre_310");
      check_col_const(309, 360, "centre_309");

      do_carve(3, 360, 8, "left_clip");
      check_col_const(0, 365, "left_col0");
      check_col_const(11, 360, "left_col11");
      check_col_const(639, 360, "left_no_wrap");

      do_carve(320, 200, 5, "no_reraise");
      check_col_const(320, 370, "no_reraise_320");

      do_carve(700, 100, 5, "empty_range");
      do_carve(500, 400, 0, "r0");
      check_col_const(500, 400, "r0_500");
      check_col_const(499, 360, "r0_499");

      do_carve(600, 470, 60, "sat_right");
      check_col_const(600, 480, "sat_600");
      check_col(639, "sat_639");
      do_carve(50, 0, 30, "shallow");
      check_col(50, "shallow_50");

      check_col(700, "blank_700");
      check_col(1023, "blank_1023");

      for (int i = 0; i < 20; i++) begin
         cx = $urandom_range(0, 700);
         cy = $urandom_range(0, 520);
         r  = $urandom_range(0, 63);
         do_carve(cx, cy, r, "rand");
         check_col(cx, "rand_cx");
         check_col($urandom_range(0, 639), "rand_col");
      end
      for (int c = 0; c < 640; c++) check_col(c, "sweep");

      // Reset while the FSM sits in CARVE_RD.
      carve_cx  = 10'd100;
      carve_cy  = 10'd300;
      carve_r   = 6'd20;
      carve_req = 1'b1;
      @(posedge clk);
      #1;
      carve_req = 1'b0;
      check_eq("midcarve_no_ack", 480'(carve_ack), 480'd0);
      apply_reset();
      for (int c = 0; c < 640; c++) check_col(c, "post_reset_sweep");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/terrain_height_map.md
# terrain_height_map

Owns the destructible terrain as a per-column heightmap and produces the 480-bit column mask `terrain_data` consumed by `color_mapper`. On reset it fills every column with a flat initial height. It then accepts crater-carve requests from the bomb/explosion logic over a req/ack handshake, and performs a read-modify-write over the affected columns. It streams the mask for the column named by `DrawX`, so `terrain_data[DrawY]` is set wherever terrain occupies that pixel.

## Interface
Parameters:
- `INIT_HEIGHT`, default 10'd360: top row of terrain after reset; rows ≥ height are terrain.
- `SCREEN_W`, default 640: number of columns.
- `SCREEN_H`, default 480: number of rows and width of the mask.

Ports:
- `clk` in 1: pixel/system clock; one clock domain.
- `Reset` in 1: synchronous, active-high.
- `DrawX` in 10: column to display, presented 2 cycles ahead of use.
- `terrain_data` out 480: bit y = 1 iff y ≥ height[DrawX]; to `color_mapper`.
- `carve_req` in 1: held high with operands stable until `carve_ack`.
- `carve_cx` in 10: crater centre column.
- `carve_cy` in 10: crater centre row.
- `carve_r` in 6: crater radius, 0..63.
- `carve_ack` out 1: one-cycle pulse when the carve has been committed.
- `busy` out 1: high in INIT and in any carve state.

## Operation
- States: INIT, IDLE, CARVE_RD, CARVE_WR.
- **Reset:**
  - state → INIT and column counter → 0.
  - `terrain_data` = 0, `carve_ack` = 0, `busy` = 1.
- **INIT:**
  - Writes `INIT_HEIGHT` to column counter, one column per cycle.
  - After column 639 is written, goes to IDLE. INIT takes exactly 640 cycles.
- **IDLE:** if `carve_req`, latches cx, cy and r, then computes the column range.
  - x_lo = max(cx − r, 0) and x_hi = min(cx + r, 639), using 11-bit signed arithmetic.
  - If cx ≥ 640, the range is empty: pulse `carve_ack` the next cycle and stay in IDLE.
  - Otherwise set x = x_lo and go to CARVE_RD.
- **CARVE_RD:** issues a RAM read of height[x], then goes to CARVE_WR.
- **CARVE_WR:** computes the new height and writes it back.
  - bottom = cy + r − |x − cx|, saturated to 480.
  - new = max(old, bottom), so terrain only ever lowers. The write is skipped if new == old.
  - If x == x_hi: pulse `carve_ack` and go to IDLE. Otherwise x++ and go to CARVE_RD.
- A carve takes 2 cycles per column, and `carve_ack` asserts in the CARVE_WR cycle of x_hi. `carve_req` must drop the cycle after the ack. A req still high 2 cycles after the ack is treated as a new request.
- A `carve_req` asserted during INIT or a carve waits; it is not lost and not latched early.
- r = 0 carves the single column cx, with bottom = cy.
- A `Reset` mid-carve or mid-INIT aborts it with no ack, clears `carve_ack`, and restarts INIT from column 0.
- Display port:
  - If DrawX ≥ 640 (blanking), `terrain_data` = 0.
  - Height 480 gives an empty mask; height 0 gives all ones.

## Timing
- Display latency: 2 cycles.
  - Cycle n: DrawX sampled and the RAM read issued.
  - n+1: height registered.
  - n+2: mask registered onto `terrain_data`.
- Display reads use a dedicated RAM port and are never stalled by INIT or carve traffic.
- Same-column read/write collision: the display port returns the old height. The new height is visible from the next read.
- `busy` is combinational from state.
- `carve_ack` is registered and high for exactly one cycle.

## Structure
- `terrain_pkg`:
  - `SCREEN_W`, `SCREEN_H`, `height_t` (logic [9:0]), `col_t` (logic [9:0]).
  - State enum `terrain_state_e`.
- Sub-module `terrain_height_ram`: 640×10 true dual-port synchronous RAM.
  - Port A: display read only.
  - Port B: FSM read/write.
  - Read-first on a collision.
- Top level holds the FSM, range and bottom arithmetic, and the mask-generation register.

## Test plan
- **Reset then init:** `Reset` 1 cycle.
  - `busy` stays high for 640 cycles.
  - Then DrawX=100 → `terrain_data` two cycles later has bits 360..479 = 1 and 0..359 = 0.
- **Centre carve:** cx=320, cy=360, r=10.
  - `carve_ack` arrives after 42 cycles.
  - height[320]=370, height[315]=365, height[310]=360, and height[309]=360 unchanged.
- **Left-edge clip:** cx=3, r=8, cy=360.
  - Columns 0..11 are touched; height[0]=365.
  - Ack after 24 cycles, with no wrap to column 639.
- **No re-raise:** carve cx=320, cy=200, r=5 after the centre carve.
  - height[320]=370 unchanged, because max keeps the deeper hole.
- **Req during INIT plus reset mid-carve:**
  - `carve_req` held from reset is serviced only after cycle 640.
  - `Reset` in CARVE_RD gives no ack, and all heights return to 360 after INIT.
- **Blanking:** DrawX=700 → `terrain_data` = 0 two cycles later.
